// File: rtl/lau_pkg.sv
// rtl/lau_pkg.sv - shared types and constant helpers for the lau arithmetic blocks
package lau_pkg;

  // Multiplier bits retired per iteration: SLOW=1, MEDIUM=2, FAST=4.
  typedef enum logic [1:0] {
    SLOW,
    MEDIUM,
    FAST
  } speed_e;

  // floor(log2(n)) for n >= 1; used for elaboration-time sizing only.
  function automatic int log2floor(input int n);
    int r;
    int v;
    r = 0;
    v = n;
    while (v > 1) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lau_mul_seq.sv
// rtl/lau_mul_seq.sv - sequential shift-add unsigned multiplier with valid/ready handshakes
module lau_mul_seq #(
  parameter int              WIDTH = 16,
  parameter lau_pkg::speed_e SPEED = lau_pkg::MEDIUM
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   p_o,
  output logic                 busy_o
);

  localparam int B     = (SPEED == lau_pkg::SLOW)   ? 1 :
                         (SPEED == lau_pkg::MEDIUM) ? 2 : 4;
  localparam int STEPS = WIDTH / B;
  // One spare bit so the counter can step past STEPS-1 without aliasing.
  localparam int CW    = lau_pkg::log2floor(STEPS) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   addend;
  logic                 accept;
  logic                 last;

  // Accept only from IDLE; clear_i vetoes a simultaneous offer.
  assign accept = (state_q == IDLE) && in_valid_i && !clear_i;
  assign last   = (cnt_q == LAST);

  // Partial product of the multiplicand with the low B multiplier bits,
  // aligned to the digit position being retired this cycle.
  assign partial = {{WIDTH{1'b0}}, mcand_q} * {{(2*WIDTH-B){1'b0}}, mplier_q[B-1:0]};
  assign addend  = partial << (cnt_q * B);

  // Status outputs are pure decodes of the state register.
  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == BUSY);
  assign out_valid_o = (state_q == DONE);
  assign p_o         = acc_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear_i overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid_i)  state_d = BUSY;
        BUSY:    if (last)        state_d = DONE;
        DONE:    if (out_ready_i) state_d = IDLE;
        default:                  state_d = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, one radix-2^B digit per BUSY cycle, accumulator held otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_q + addend;
      mplier_q <= mplier_q >> B;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_lau_mul_seq.sv
// tb/tb_lau_mul_seq.sv - scoreboard bench for lau_mul_seq at SLOW, MEDIUM and FAST
module tb_lau_mul_seq;
  import lau_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           clear;
  logic           in_valid;
  logic           out_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] p;

  logic           x_in_valid  [2];
  logic           x_in_ready  [2];
  logic           x_out_valid [2];
  logic           x_busy      [2];
  logic [2*W-1:0] x_p         [2];

  logic [2*W-1:0] exp_q [$];
  int             checks = 0;
  int             errors = 0;
  bit             rand_ready = 1'b0;

  lau_mul_seq #(.WIDTH(W), .SPEED(MEDIUM)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .p_o(p), .busy_o(busy)
  );

  lau_mul_seq #(.WIDTH(W), .SPEED(SLOW)) dut_slow (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(x_in_valid[0]), .in_ready_o(x_in_ready[0]), .a_i(a), .b_i(b),
    .out_valid_o(x_out_valid[0]), .out_ready_i(1'b1), .p_o(x_p[0]), .busy_o(x_busy[0])
  );

  lau_mul_seq #(.WIDTH(W), .SPEED(FAST)) dut_fast (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(x_in_valid[1]), .in_ready_o(x_in_ready[1]), .a_i(a), .b_i(b),
    .out_valid_o(x_out_valid[1]), .out_ready_i(1'b1), .p_o(x_p[1]), .busy_o(x_busy[1])
  );

  function automatic logic [2*W-1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    wa = {{W{1'b0}}, aa};
    wb = {{W{1'b0}}, bb};
    return wa * wb;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the oldest accepted pair.
  always @(negedge clk) begin
    #1;
    if (rst_n && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", p);
      end else begin
        chk("product", p, exp_q.pop_front());
      end
    end
  end

  // Random back-pressure while enabled.
  always @(negedge clk) begin
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Offer a pair (called just after a negedge) and wait, bounded, for it to be taken.
  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb);
    int n;
    n = 0;
    a = aa;
    b = bb;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else begin
      exp_q.push_back(model(aa, bb));
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Accept on the next edge and measure cycles to out_valid and BUSY cycles seen.
  task automatic timed(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       output int lat, output int nb);
    lat = 0;
    nb  = 0;
    chk("ready_before_accept", in_ready, 1);
    a = aa;
    b = bb;
    in_valid = 1'b1;
    exp_q.push_back(model(aa, bb));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic timed_x(input int k, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output int lat, output int nb);
    lat = 0;
    nb  = 0;
    a = aa;
    b = bb;
    x_in_valid[k] = 1'b1;
    @(negedge clk);
    x_in_valid[k] = 1'b0;
    lat = 1;
    while (!x_out_valid[k] && lat < 100) begin
      if (x_busy[k]) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_reached", out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    int nb;
    bit saw;
    logic [2*W-1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; x_in_valid[0] = 1'b0; x_in_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_p", p, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones operands, latency and BUSY count at MEDIUM.
    timed(16'hFFFF, 16'hFFFF, lat, nb);
    chk("lat_ffff", lat, 9);
    chk("busy_ffff", nb, 8);
    chk("p_ffff", p, 32'hFFFE0001);
    @(negedge clk);

    // Same pair at all three speeds.
    timed(16'h1234, 16'h00AB, lat, nb);
    chk("busy_medium", nb, 8);
    chk("lat_medium", lat, 9);
    @(negedge clk);
    timed_x(0, 16'h1234, 16'h00AB, lat, nb);
    chk("busy_slow", nb, 16);
    chk("lat_slow", lat, 17);
    chk("p_slow", x_p[0], model(16'h1234, 16'h00AB));
    @(negedge clk);
    timed_x(1, 16'h1234, 16'h00AB, lat, nb);
    chk("busy_fast", nb, 4);
    chk("lat_fast", lat, 5);
    chk("p_fast", x_p[1], model(16'h1234, 16'h00AB));
    @(negedge clk);

    // Back-pressure in DONE while a second pair is offered.
    out_ready = 1'b0;
    issue(16'h1234, 16'h5678);
    wait_valid();
    held = model(16'h1234, 16'h5678);
    in_valid = 1'b1;
    a = 16'h0003;
    b = 16'h0003;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_p", p, held);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_p_held", p, held);
    @(negedge clk);
    chk("post_hs_busy", busy, 0);
    chk("no_second_accept", exp_q.size(), 0);

    // clear_i in the third BUSY cycle.
    a = 16'h00FF;
    b = 16'h0F0F;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_in_ready", in_ready, 1);
    chk("clear_busy", busy, 0);
    chk("clear_out_valid", out_valid, 0);
    chk("clear_p", p, 0);
    clear = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clear_blocks_accept", busy, 0);
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("no_output_after_clear", saw, 0);
    issue(16'd3, 16'd5);
    wait_valid();
    chk("p_3x5", p, 32'd15);
    drain();
    @(negedge clk);

    // Reset asserted during DONE.
    out_ready = 1'b0;
    issue(16'hABCD, 16'h1357);
    wait_valid();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    timed(16'h0000, 16'hFFFF, lat, nb);
    chk("lat_after_reset", lat, 9);
    chk("p_zero", p, 0);
    @(negedge clk);

    // Randomized back-to-back traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = '1;
        default: rb = W'($urandom);
      endcase
      issue(ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
